// File: rtl/reg_file_sb.sv
// Integer register file with two write ports (single-cycle ALU and long-latency
// writeback), optional write-to-read forwarding and a per-register busy
// scoreboard for outstanding long-latency results. Register 0 reads as zero.
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic wr0_en, wr1_en;

  // Port 1 wins a same-address collision, so port 0 is suppressed in that case.
  assign wr1_en = we1 && (waddr1 != '0);
  assign wr0_en = we0 && (waddr0 != '0) && !(we1 && (waddr1 == waddr0));

  // Register array update; reset clears every entry including x0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr0_en) regs_q[waddr0] <= wdata0;
      if (wr1_en) regs_q[waddr1] <= wdata1;
    end
  end

  // Scoreboard next state: clear on writeback first, so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (we1) busy_d[waddr1] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            hit0, hit1;

    assign ra   = raddr[k*AW +: AW];
    assign hit0 = (BYPASS != 0) && we0 && (waddr0 == ra);
    assign hit1 = (BYPASS != 0) && we1 && (waddr1 == ra);

    // Read mux: x0 forced to zero, then forwarding with port-1 priority.
    always_comb begin
      rd = regs_q[ra];
      if (ra == '0)  rd = '0;
      else if (hit1) rd = wdata1;
      else if (hit0) rd = wdata0;
    end

    assign rdata[k*XLEN +: XLEN] = rd;
    // A writeback landing this cycle already satisfies the dependency when forwarding.
    assign rbusy[k] = (ra != '0) && busy_q[ra] && !hit1;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default instance, a BYPASS=0 twin sharing
// its stimulus, and a wide 64-bit/16-entry/3-port instance.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for default (a) and no-bypass (b) instances.
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        we0, we1, issue_valid;
  logic [4:0]  waddr0, waddr1, issue_rd, dbg_addr;
  logic [31:0] wdata0, wdata1, dbg_a, dbg_b;

  // Wide instance (c).
  logic [11:0]  raddr_c;
  logic [191:0] rdata_c;
  logic [2:0]   rbusy_c;
  logic         we0_c, we1_c, iv_c;
  logic [3:0]   waddr0_c, waddr1_c, ird_c, dbga_c;
  logic [63:0]  wdata0_c, wdata1_c, dbg_c;

  reg_file_sb dut_a (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .raddr(raddr_c), .rdata(rdata_c), .rbusy(rbusy_c),
    .we0(we0_c), .waddr0(waddr0_c), .wdata0(wdata0_c),
    .we1(we1_c), .waddr1(waddr1_c), .wdata1(wdata1_c),
    .issue_valid(iv_c), .issue_rd(ird_c), .dbg_addr(dbga_c), .dbg_data(dbg_c)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h required=<queued expectation>", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0; we0 = 0; we1 = 0; issue_valid = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; issue_rd = '0; dbg_addr = '0;
    raddr_c = '0; we0_c = 0; we1_c = 0; iv_c = 0;
    waddr0_c = '0; waddr1_c = '0; wdata0_c = '0; wdata1_c = '0; ird_c = '0; dbga_c = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state.
    raddr = {5'd31, 5'd5}; dbg_addr = 5'd17;
    push("rst_rdata", 64'h0); push("rst_rbusy", 64'h0); push("rst_dbg", 64'h0);
    #1; chk(rdata_a); chk({62'h0, rbusy_a}); chk({32'h0, dbg_a});

    // ALU write, read next cycle; write to x0 discarded, never forwarded.
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234_5678;
    step(); idle(); raddr = {5'd0, 5'd5};
    push("x5_a", 64'h1234_5678); push("x5_b", 64'h1234_5678);
    #1; chk({32'h0, rdata_a[31:0]}); chk({32'h0, rdata_b[31:0]});
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; raddr = {5'd0, 5'd0};
    push("x0_fwd", 64'h0); #1; chk(rdata_a);
    step(); idle(); dbg_addr = 5'd0;
    push("x0_after", 64'h0); push("x0_dbg", 64'h0);
    #1; chk(rdata_a); chk({32'h0, dbg_a});

    // Same-cycle long-latency write forwarding vs. no bypass.
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'hA5A5_A5A5; raddr = {5'd7, 5'd0};
    push("byp_a", 64'hA5A5_A5A5); push("byp_b_old", 64'h0);
    #1; chk({32'h0, rdata_a[63:32]}); chk({32'h0, rdata_b[63:32]});
    step(); idle();
    push("nobyp_next", 64'hA5A5_A5A5); #1; chk({32'h0, rdata_b[63:32]});

    // Both ports to x9: port 1 wins, forwarded and committed.
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'h1; we1 = 1; waddr1 = 5'd9; wdata1 = 32'h2;
    raddr = {5'd0, 5'd9};
    push("prio_fwd", 64'h2); #1; chk({32'h0, rdata_a[31:0]});
    step(); idle(); dbg_addr = 5'd9;
    push("prio_a", 64'h2); push("prio_b", 64'h2); push("prio_dbg", 64'h2);
    #1; chk({32'h0, rdata_a[31:0]}); chk({32'h0, rdata_b[31:0]}); chk({32'h0, dbg_a});

    // Scoreboard set / clear / collision.
    issue_valid = 1; issue_rd = 5'd3; raddr = {5'd0, 5'd3};
    push("busy_pre", 64'h0); #1; chk({63'h0, rbusy_a[0]});
    step(); idle();
    push("busy_set_a", 64'h1); push("busy_set_b", 64'h1);
    #1; chk({63'h0, rbusy_a[0]}); chk({63'h0, rbusy_b[0]});
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h0000_0033;
    step(); idle();
    push("busy_keep_we0", 64'h1); #1; chk({63'h0, rbusy_a[0]});
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'hDEAD_BEEF;
    push("busy_clr_fwd_a", 64'h0); push("busy_clr_fwd_b", 64'h1); push("wb_fwd", 64'hDEAD_BEEF);
    #1; chk({63'h0, rbusy_a[0]}); chk({63'h0, rbusy_b[0]}); chk({32'h0, rdata_a[31:0]});
    step(); idle();
    push("busy_clr_a", 64'h0); push("busy_clr_b", 64'h0); push("wb_data", 64'hDEAD_BEEF);
    #1; chk({63'h0, rbusy_a[0]}); chk({63'h0, rbusy_b[0]}); chk({32'h0, rdata_b[31:0]});
    issue_valid = 1; issue_rd = 5'd3; we1 = 1; waddr1 = 5'd3; wdata1 = 32'h0000_0044;
    step(); idle();
    push("issue_wins_a", 64'h1); push("issue_wins_b", 64'h1);
    #1; chk({63'h0, rbusy_a[0]}); chk({63'h0, rbusy_b[0]});

    // Writeback to a non-busy register.
    we1 = 1; waddr1 = 5'd11; wdata1 = 32'h77; step(); idle(); raddr = {5'd11, 5'd0};
    push("wb_nonbusy_data", 64'h77); push("wb_nonbusy_busy", 64'h0);
    #1; chk({32'h0, rdata_a[63:32]}); chk({63'h0, rbusy_a[1]});

    // Reset mid-operation with writes and issue active.
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'h55; issue_valid = 1; issue_rd = 5'd6;
    step(); idle(); raddr = {5'd6, 5'd4};
    push("pre_rst_x4", 64'h55); push("pre_rst_busy6", 64'h1);
    #1; chk({32'h0, rdata_a[31:0]}); chk({63'h0, rbusy_a[1]});
    rst_n = 0; we0 = 1; waddr0 = 5'd4; wdata0 = 32'h99; issue_valid = 1; issue_rd = 5'd6;
    step(); idle(); rst_n = 1;
    push("rst_x4", 64'h0); push("rst_busy6", 64'h0);
    #1; chk({32'h0, rdata_a[31:0]}); chk({63'h0, rbusy_a[1]});
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      push($sformatf("rst_dbg_x%0d", i), 64'h0);
      #1; chk({32'h0, dbg_a});
    end
    we1 = 1; waddr1 = 5'd6; wdata1 = 32'h3; step(); idle();
    push("post_rst_wb_data", 64'h3); push("post_rst_wb_busy", 64'h0);
    #1; chk({32'h0, rdata_a[63:32]}); chk({63'h0, rbusy_a[1]});

    // Wide instance: 64-bit write to x15 on all three ports, plus forwarding.
    we0_c = 1; waddr0_c = 4'd15; wdata0_c = 64'hFFFF_FFFF_0000_0001;
    step(); we0_c = 0; raddr_c = {4'd15, 4'd15, 4'd15};
    for (int k = 0; k < 3; k++) push($sformatf("wide_p%0d", k), 64'hFFFF_FFFF_0000_0001);
    #1; chk(rdata_c[63:0]); chk(rdata_c[127:64]); chk(rdata_c[191:128]);
    we1_c = 1; waddr1_c = 4'd14; wdata1_c = 64'h8000_0000_0000_00AB; raddr_c = {4'd14, 4'd0, 4'd15};
    push("wide_fwd", 64'h8000_0000_0000_00AB); push("wide_x0", 64'h0);
    #1; chk(rdata_c[191:128]); chk(rdata_c[127:64]);
    step(); we1_c = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
